sram_arbiter: RTL
=================

Name: sram_arbiter

Overview:
- Shares the single-port 8-bit SRAM between NUM_REQ requesters: operand loader, multiplier read engine, and result write-back.
- Round-robin arbitration with an optional per-requester lock for bursts.
- Registered SRAM command outputs; read data returns with a fixed latency.
- Sits between the matrix-multiplier engines and the SRAM instance, and owns every SRAM port.

Parameters:
- NUM_REQ, 3, number of requesters; index 0 has the highest tie priority after reset.
- ADDR_W, 10, SRAM address width.
- DATA_W, 8, SRAM data width.
- MEM_DEPTH, 543, number of valid SRAM locations; legal addresses are 0..MEM_DEPTH-1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  request valid, one bit per requester.
- req_we  in  NUM_REQ  1 = write, 0 = read.
- req_lock  in  NUM_REQ  keep the grant after this beat.
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i occupies bits [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_REQ*DATA_W  packed write data.
- req_ready  out  NUM_REQ  one-hot or zero; combinational grant.
- rsp_valid  out  NUM_REQ  read-response pulse for the requester that issued the read.
- rsp_rdata  out  DATA_W  shared read-data bus.
- oob_err  out  NUM_REQ  one-cycle pulse when an accepted request is out of range.
- sram_we  out  1  SRAM write enable, registered.
- sram_addr  out  ADDR_W  SRAM address, registered.
- sram_din  out  DATA_W  SRAM write data, registered.
- sram_dout  in  DATA_W  SRAM registered read data.

Behaviour:
- Reset values (async, immediate): sram_we=0, sram_addr=0, sram_din=0, rsp_valid=0, rsp_rdata=0, oob_err=0.
  - Internal state clears: rr pointer=0, lock owner=none, response pipeline empty.
  - In-flight reads are dropped with no rsp_valid. A write already registered toward the SRAM may or may not land.
- Grant (combinational):
  - If lock owner L exists and req_valid[L]=1, then ready[L]=1 and no other ready bit is set.
  - Otherwise grant the first i with req_valid[i]=1, scanning ptr, ptr+1, …, wrapping mod NUM_REQ.
  - ready[i]=1 only when req_valid[i]=1. req_ready never has more than one bit set.
- Accept: a beat is accepted in cycle N when valid[i] & ready[i].
  - ptr <= (i+1) mod NUM_REQ.
  - Lock owner <= i if req_lock[i]=1, else none.
  - If owner L drops valid, the lock is released that cycle and arbitration falls to the round-robin scan.
- Command pipeline:
  - Cycle N+1: sram_we/addr/din hold the accepted beat.
  - With no acceptance in N, sram_we=0 in N+1; sram_addr and sram_din hold their previous values.
- Read latency: a read accepted in N gives rsp_valid[i]=1 with rsp_rdata=sram_dout in cycle N+2. Throughput is one access per cycle.
  - Back-to-back reads from different requesters give back-to-back responses, in order, each tagged by its rsp_valid bit.
  - rsp_rdata holds its last value when rsp_valid=0.
- Write: no response is issued. A write in N followed by a read of the same address in N+1 returns the new data.
- Out of range (addr >= MEM_DEPTH):
  - The beat is still accepted and oob_err[i] pulses in N+1.
  - A write is suppressed (sram_we stays 0).
  - A read still produces rsp_valid in N+2, with rsp_rdata=0.
- Simultaneous events: all requesters valid in the same cycle → exactly one grant; the others see ready=0 and must hold their request stable.
- Requesters may drop valid without acceptance. The block never latches a request that was not accepted.

Decomposition:
- Package sram_arb_pkg holds ADDR_W, DATA_W, MEM_DEPTH, NUM_REQ defaults and the localparam PTR_W = clog2(NUM_REQ).
- Sub-module rr_arbiter: combinational rotate-priority one-hot grant from req vector + ptr. The lock override and all registers stay in sram_arbiter.
- The bench instantiates sram_arbiter together with the existing SRAM model.

Test Plan:
- Single read: reset, SRAM preloaded mem[5]=8'hA5; req0 reads addr 5 in cycle 2 → ready[0]=1 in cycle 2; sram_addr=5, sram_we=0 in cycle 3; rsp_valid[0]=1 with rsp_rdata=8'hA5 in cycle 4.
- Round-robin fairness: all three requesters hold valid reads for 6 cycles → grant order 0,1,2,0,1,2; responses arrive in the same order, 2 cycles later each.
- Lock burst: req1 writes addr 10..13 with lock=1 (lock=0 on the last beat) while req0 and req2 are valid → req1 gets 4 consecutive grants, then req2, then req0; mem[10..13] hold the written data.
- Write-then-read: req2 writes 8'h3C to addr 542 in cycle N; req0 reads addr 542 in cycle N+1 → rsp_rdata=8'h3C in cycle N+3.
- Out of range: req0 writes addr 543, then reads addr 600 → oob_err[0] pulses in each following cycle; sram_we stays 0; the read response is 8'h00.
- Reset mid-read: assert rst one cycle after a read is accepted → rsp_valid stays 0; all outputs return to reset values immediately.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared defaults and helpers for the SRAM arbiter slice.
package sram_arb_pkg;

  localparam int DEF_NUM_REQ   = 3;
  localparam int DEF_ADDR_W    = 10;
  localparam int DEF_DATA_W    = 8;
  localparam int DEF_MEM_DEPTH = 543;

  // Pointer width that still works for a single requester.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int PTR_W = ptr_width(DEF_NUM_REQ);

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority arbiter: one-hot grant to the first set
// request at or after i_ptr, wrapping around.
module rr_arbiter
  import sram_arb_pkg::*;
#(
  parameter int N  = DEF_NUM_REQ,
  parameter int PW = ptr_width(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt
);

  int w_idx;

  // NOTE: every variable written in always_comb gets a default first so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    o_gnt = '0;
    w_idx = 0;
    // Walk from the farthest slot back to ptr so the nearest request wins.
    for (int k = N - 1; k >= 0; k--) begin
      w_idx = (int'(i_ptr) + k) % N;
      if (i_req[w_idx]) begin
        o_gnt        = '0;
        o_gnt[w_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Round-robin arbiter with burst lock that owns the single-port SRAM:
// registered command outputs, read data returned two cycles after accept.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MEM_DEPTH = DEF_MEM_DEPTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ-1:0]          req_we,
  input  logic [NUM_REQ-1:0]          req_lock,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [NUM_REQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]           rsp_rdata,
  output logic [NUM_REQ-1:0]          oob_err,
  output logic                        sram_we,
  output logic [ADDR_W-1:0]           sram_addr,
  output logic [DATA_W-1:0]           sram_din,
  input  logic [DATA_W-1:0]           sram_dout
);

  localparam int              L_PTR_W = ptr_width(NUM_REQ);
  localparam logic [ADDR_W:0] L_DEPTH = (ADDR_W + 1)'(MEM_DEPTH);

  logic [L_PTR_W-1:0] r_ptr;
  logic               r_lock_v;
  logic [L_PTR_W-1:0] r_lock_id;

  logic               r_sram_we;
  logic [ADDR_W-1:0]  r_sram_addr;
  logic [DATA_W-1:0]  r_sram_din;
  logic [NUM_REQ-1:0] r_oob_err;
  logic [NUM_REQ-1:0] r_rd_v1;
  logic               r_rd_oob1;
  logic [NUM_REQ-1:0] r_rsp_valid;
  logic               r_rsp_oob;
  logic [DATA_W-1:0]  r_rdata_hold;

  logic [NUM_REQ-1:0] w_rr_gnt;
  logic [NUM_REQ-1:0] w_gnt;
  logic [L_PTR_W-1:0] w_gnt_idx;
  logic [L_PTR_W-1:0] w_ptr_nxt;
  logic               w_accept;
  logic               w_we;
  logic               w_lock;
  logic               w_oob;
  logic [ADDR_W-1:0]  w_addr;
  logic [DATA_W-1:0]  w_wdata;
  logic [DATA_W-1:0]  w_rdata;

  rr_arbiter #(.N(NUM_REQ), .PW(L_PTR_W)) u_rr (
    .i_req (req_valid),
    .i_ptr (r_ptr),
    .o_gnt (w_rr_gnt)
  );

  // A live lock owner overrides the round-robin choice.
  always_comb begin
    w_gnt = w_rr_gnt;
    if (r_lock_v && req_valid[r_lock_id]) begin
      w_gnt            = '0;
      w_gnt[r_lock_id] = 1'b1;
    end
  end

  always_comb begin
    w_gnt_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt[i]) w_gnt_idx = L_PTR_W'(i);
    end
  end

  assign req_ready = w_gnt;
  assign w_accept  = |w_gnt;
  assign w_we      = req_we[w_gnt_idx];
  assign w_lock    = req_lock[w_gnt_idx];
  assign w_addr    = req_addr[int'(w_gnt_idx)*ADDR_W +: ADDR_W];
  assign w_wdata   = req_wdata[int'(w_gnt_idx)*DATA_W +: DATA_W];
  assign w_oob     = ({1'b0, w_addr} >= L_DEPTH);
  assign w_ptr_nxt = (int'(w_gnt_idx) == NUM_REQ - 1) ? '0 : w_gnt_idx + 1'b1;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its sources regardless of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr     <= '0;
      r_lock_v  <= 1'b0;
      r_lock_id <= '0;
    end else begin
      // With no acceptance the owner has dropped valid, so the lock lapses.
      r_lock_v <= w_accept && w_lock;
      if (w_accept) begin
        r_ptr     <= w_ptr_nxt;
        r_lock_id <= w_gnt_idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sram_we   <= 1'b0;
      r_sram_addr <= '0;
      r_sram_din  <= '0;
      r_oob_err   <= '0;
      r_rd_v1     <= '0;
      r_rd_oob1   <= 1'b0;
    end else begin
      r_sram_we <= w_accept && w_we && !w_oob;
      r_oob_err <= (w_accept && w_oob) ? w_gnt : '0;
      r_rd_v1   <= (w_accept && !w_we) ? w_gnt : '0;
      r_rd_oob1 <= w_oob;
      if (w_accept) begin
        r_sram_addr <= w_addr;
        r_sram_din  <= w_wdata;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_valid  <= '0;
      r_rsp_oob    <= 1'b0;
      r_rdata_hold <= '0;
    end else begin
      r_rsp_valid  <= r_rd_v1;
      r_rsp_oob    <= r_rd_oob1;
      r_rdata_hold <= w_rdata;
    end
  end

  // The SRAM output register lines up with the response cycle.
  assign w_rdata = (|r_rsp_valid) ? (r_rsp_oob ? '0 : sram_dout) : r_rdata_hold;

  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = w_rdata;
  assign oob_err   = r_oob_err;
  assign sram_we   = r_sram_we;
  assign sram_addr = r_sram_addr;
  assign sram_din  = r_sram_din;

endmodule
